// File: rtl/sequencer_burst_rx.sv
// Receive-side burst sequencer: buffers 96-bit MAC packets in a small FIFO and
// unpacks each one into red/green/blue RAM words at a shared incrementing address.
module sequencer_burst_rx #(
   parameter int RAM_ADDR_WIDTH = 14,
   parameter int RAM_DATA_WIDTH = 32,
   parameter int BUF_DEPTH      = 4,
   parameter int PIXEL_COUNT    = 65536
) (
   input  logic                          wr_clk,
   input  logic                          rst_n,
   input  logic [95:0]                   pkt_data,
   input  logic                          pkt_valid,
   output logic                          pkt_ready,
   output logic [RAM_ADDR_WIDTH-1:0]     red_RAM_addr,
   output logic [RAM_ADDR_WIDTH-1:0]     green_RAM_addr,
   output logic [RAM_ADDR_WIDTH-1:0]     blue_RAM_addr,
   output logic [RAM_DATA_WIDTH-1:0]     red_RAM_data,
   output logic [RAM_DATA_WIDTH-1:0]     green_RAM_data,
   output logic [RAM_DATA_WIDTH-1:0]     blue_RAM_data,
   output logic                          red_write_en,
   output logic                          green_write_en,
   output logic                          blue_write_en,
   input  logic                          activate_burst,
   input  logic                          img_ctrl_start,
   output logic                          rx_frame_active,
   output logic                          img_complete,
   output logic [$clog2(PIXEL_COUNT):0]  pixel_counter
);
   // state | meaning
   // IDLE  | waiting for activate_burst & img_ctrl_start
   // RECV  | accepting packets and writing one RAM word per buffered packet
   // DONE  | whole frame written; held until start or enable drops
   localparam int TOTAL_ADDR = PIXEL_COUNT / 4;
   localparam int ACNT_W     = $clog2(TOTAL_ADDR + 1);
   localparam int PTR_W      = $clog2(BUF_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam logic [ACNT_W-1:0] TOTAL_CNT = ACNT_W'(TOTAL_ADDR);
   localparam logic [ACNT_W-1:0] LAST_CNT  = ACNT_W'(TOTAL_ADDR - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t              state;
   logic [95:0]         fifo_mem [BUF_DEPTH];
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [ACNT_W-1:0]   acc_cnt;
   logic [ACNT_W-1:0]   wr_addr_cnt;
   logic                fifo_full;
   logic                fifo_empty;
   logic                accept;
   logic                wr_en_gate;
   logic [95:0]         head;

   assign fifo_full  = (fifo_cnt == DEPTH_CNT);
   assign fifo_empty = (fifo_cnt == '0);
   assign pkt_ready  = (state == RECV) & ~fifo_full & (acc_cnt < TOTAL_CNT) & activate_burst;
   assign accept     = pkt_valid & pkt_ready;
   assign wr_en_gate = (state == RECV) & ~fifo_empty & activate_burst;
   assign head       = fifo_mem[rd_ptr];

   assign red_RAM_addr   = wr_addr_cnt[RAM_ADDR_WIDTH-1:0];
   assign green_RAM_addr = wr_addr_cnt[RAM_ADDR_WIDTH-1:0];
   assign blue_RAM_addr  = wr_addr_cnt[RAM_ADDR_WIDTH-1:0];
   assign red_write_en   = wr_en_gate;
   assign green_write_en = wr_en_gate;
   assign blue_write_en  = wr_en_gate;
   assign pixel_counter  = {wr_addr_cnt, 2'b00};

   // Byte k of each colour word carries pixel k of the packet.
   always_comb begin
      red_RAM_data   = '0;
      green_RAM_data = '0;
      blue_RAM_data  = '0;
      if (wr_en_gate) begin
         red_RAM_data   = {head[95:88], head[71:64], head[47:40], head[23:16]};
         green_RAM_data = {head[87:80], head[63:56], head[39:32], head[15:8]};
         blue_RAM_data  = {head[79:72], head[55:48], head[31:24], head[7:0]};
      end
   end

   always_ff @(posedge wr_clk) begin
      if (accept) fifo_mem[wr_ptr] <= pkt_data;
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         fifo_cnt        <= '0;
         acc_cnt         <= '0;
         wr_addr_cnt     <= '0;
         rx_frame_active <= 1'b0;
         img_complete    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (activate_burst & img_ctrl_start) begin
                  state       <= RECV;
                  rd_ptr      <= '0;
                  wr_ptr      <= '0;
                  fifo_cnt    <= '0;
                  acc_cnt     <= '0;
                  wr_addr_cnt <= '0;
               end
            end
            RECV: begin
               if (!activate_burst) begin
                  state           <= IDLE;
                  rd_ptr          <= '0;
                  wr_ptr          <= '0;
                  fifo_cnt        <= '0;
                  acc_cnt         <= '0;
                  wr_addr_cnt     <= '0;
                  rx_frame_active <= 1'b0;
               end else begin
                  if (accept) begin
                     wr_ptr          <= wr_ptr + 1'b1;
                     acc_cnt         <= acc_cnt + 1'b1;
                     rx_frame_active <= 1'b1;
                  end
                  if (wr_en_gate) begin
                     rd_ptr      <= rd_ptr + 1'b1;
                     wr_addr_cnt <= wr_addr_cnt + 1'b1;
                     if (wr_addr_cnt == LAST_CNT) begin
                        state           <= DONE;
                        rx_frame_active <= 1'b0;
                        img_complete    <= 1'b1;
                     end
                  end
                  case ({accept, wr_en_gate})
                     2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                     2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                     default: fifo_cnt <= fifo_cnt;
                  endcase
               end
            end
            DONE: begin
               if (!img_ctrl_start | !activate_burst) begin
                  state        <= IDLE;
                  img_complete <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequencer_burst_rx.sv
// Bench for sequencer_burst_rx: queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sequencer_burst_rx;
   localparam int PIXEL_COUNT    = 64;
   localparam int BUF_DEPTH      = 4;
   localparam int RAM_ADDR_WIDTH = 4;
   localparam int RAM_DATA_WIDTH = 32;
   localparam int TOTAL          = PIXEL_COUNT / 4;
   localparam int PC_W           = $clog2(PIXEL_COUNT) + 1;

   logic                      wr_clk = 1'b0;
   logic                      rst_n;
   logic [95:0]               pkt_data;
   logic                      pkt_valid;
   logic                      pkt_ready;
   logic [RAM_ADDR_WIDTH-1:0] red_RAM_addr, green_RAM_addr, blue_RAM_addr;
   logic [RAM_DATA_WIDTH-1:0] red_RAM_data, green_RAM_data, blue_RAM_data;
   logic                      red_write_en, green_write_en, blue_write_en;
   logic                      activate_burst;
   logic                      img_ctrl_start;
   logic                      rx_frame_active;
   logic                      img_complete;
   logic [PC_W-1:0]           pixel_counter;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 wr_clk = ~wr_clk;

   sequencer_burst_rx #(
      .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
      .RAM_DATA_WIDTH(RAM_DATA_WIDTH),
      .BUF_DEPTH(BUF_DEPTH),
      .PIXEL_COUNT(PIXEL_COUNT)
   ) dut (
      .wr_clk(wr_clk),
      .rst_n(rst_n),
      .pkt_data(pkt_data),
      .pkt_valid(pkt_valid),
      .pkt_ready(pkt_ready),
      .red_RAM_addr(red_RAM_addr),
      .green_RAM_addr(green_RAM_addr),
      .blue_RAM_addr(blue_RAM_addr),
      .red_RAM_data(red_RAM_data),
      .green_RAM_data(green_RAM_data),
      .blue_RAM_data(blue_RAM_data),
      .red_write_en(red_write_en),
      .green_write_en(green_write_en),
      .blue_write_en(blue_write_en),
      .activate_burst(activate_burst),
      .img_ctrl_start(img_ctrl_start),
      .rx_frame_active(rx_frame_active),
      .img_complete(img_complete),
      .pixel_counter(pixel_counter)
   );

   task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [95:0] mk(int k);
      logic [7:0] b;
      b = 8'(k);
      return {12{b}};
   endfunction

   // Colour c: 2 = red, 1 = green, 0 = blue; word byte px comes from pixel px.
   function automatic logic [31:0] chan(logic [95:0] p, int c);
      logic [31:0] w;
      w = '0;
      for (int px = 0; px < 4; px++) w[8*px +: 8] = p[24*px + 8*c +: 8];
      return w;
   endfunction

   // Reference model: frame phase 0 idle, 1 receiving, 2 complete.
   int          m_phase;
   logic [95:0] m_q[$];
   int          m_acc, m_wr;
   bit          m_active, m_complete;
   bit          stall = 1'b0;

   int          cyc = 0;
   int          n_acc = 0;
   int          a_cyc[$];
   int          w_addr[$];
   int          w_cyc[$];
   logic [31:0] w_red[$], w_grn[$], w_blu[$];

   always @(negedge wr_clk) begin
      bit e_ready, e_wr, do_acc;
      cyc++;
      if (!rst_n) begin
         m_phase = 0; m_q.delete(); m_acc = 0; m_wr = 0;
         m_active = 1'b0; m_complete = 1'b0;
      end
      e_ready = (m_phase == 1) && (m_q.size() < BUF_DEPTH) && (m_acc < TOTAL) && activate_burst;
      e_wr    = (m_phase == 1) && (m_q.size() > 0) && activate_burst && !stall;
      chk("pkt_ready", 96'(pkt_ready), 96'(e_ready));
      chk("write_en", 96'({red_write_en, green_write_en, blue_write_en}), e_wr ? 96'(3'b111) : 96'(0));
      chk("red_data",   96'(red_RAM_data),   e_wr ? 96'(chan(m_q[0], 2)) : 96'(0));
      chk("green_data", 96'(green_RAM_data), e_wr ? 96'(chan(m_q[0], 1)) : 96'(0));
      chk("blue_data",  96'(blue_RAM_data),  e_wr ? 96'(chan(m_q[0], 0)) : 96'(0));
      chk("addr", 96'({red_RAM_addr, green_RAM_addr, blue_RAM_addr}),
          96'({3{4'(m_wr % TOTAL)}}));
      chk("pixel_counter", 96'(pixel_counter), 96'(m_wr * 4));
      chk("rx_frame_active", 96'(rx_frame_active), 96'(m_active));
      chk("img_complete", 96'(img_complete), 96'(m_complete));

      if (red_write_en) begin
         w_addr.push_back(int'(red_RAM_addr));
         w_red.push_back(red_RAM_data);
         w_grn.push_back(green_RAM_data);
         w_blu.push_back(blue_RAM_data);
         w_cyc.push_back(cyc);
      end
      if (pkt_valid && pkt_ready) begin
         n_acc++;
         a_cyc.push_back(cyc);
      end

      if (rst_n) begin
         do_acc = pkt_valid && e_ready;
         case (m_phase)
            0: if (activate_burst && img_ctrl_start) begin
                  m_phase = 1; m_q.delete(); m_acc = 0; m_wr = 0;
               end
            1: if (!activate_burst) begin
                  m_phase = 0; m_q.delete(); m_acc = 0; m_wr = 0; m_active = 1'b0;
               end else begin
                  if (e_wr) begin void'(m_q.pop_front()); m_wr++; end
                  if (do_acc) begin m_q.push_back(pkt_data); m_acc++; m_active = 1'b1; end
                  if (m_wr == TOTAL) begin m_phase = 2; m_active = 1'b0; m_complete = 1'b1; end
               end
            default: if (!img_ctrl_start || !activate_burst) begin
                  m_phase = 0; m_complete = 1'b0;
               end
         endcase
      end
   end

   task automatic cyc1();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic clear_logs();
      n_acc = 0;
      a_cyc.delete(); w_addr.delete(); w_cyc.delete();
      w_red.delete(); w_grn.delete(); w_blu.delete();
   endtask

   task automatic run_until_writes(int nwr, int budget, bit rnd, string name);
      int k = 0;
      while (w_addr.size() < nwr && k < budget) begin
         if (rnd) begin
            pkt_valid = ($urandom_range(0, 99) < 65);
            pkt_data  = {$urandom(), $urandom(), $urandom()};
         end else begin
            pkt_valid = 1'b1;
            pkt_data  = mk(n_acc);
         end
         cyc1();
         k++;
      end
      chk({name, "_writes_reached"}, 96'(w_addr.size() >= nwr), 96'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] kb;
      rst_n = 1'b0; pkt_valid = 1'b0; pkt_data = '0;
      activate_burst = 1'b0; img_ctrl_start = 1'b0;
      repeat (3) cyc1();
      rst_n = 1'b1;
      cyc1();
      chk("reset_pkt_ready", 96'(pkt_ready), 96'(0));
      chk("reset_pixel_counter", 96'(pixel_counter), 96'(0));
      chk("reset_img_complete", 96'(img_complete), 96'(0));
      chk("reset_write_en", 96'(red_write_en), 96'(0));

      // Not armed: valid pulses in IDLE must be ignored.
      clear_logs();
      activate_burst = 1'b1; img_ctrl_start = 1'b0; pkt_valid = 1'b1; pkt_data = mk(9);
      repeat (4) cyc1();
      activate_burst = 1'b0; img_ctrl_start = 1'b1;
      repeat (3) cyc1();
      pkt_valid = 1'b0;
      chk("idle_accepts", 96'(n_acc), 96'(0));
      chk("idle_writes", 96'(w_addr.size()), 96'(0));
      chk("idle_pixel_counter", 96'(pixel_counter), 96'(0));

      // Streaming frame, packet k = {12{k}}.
      clear_logs();
      activate_burst = 1'b1; img_ctrl_start = 1'b1;
      run_until_writes(TOTAL, 100, 1'b0, "stream");
      chk("stream_img_complete", 96'(img_complete), 96'(1));
      chk("stream_pixel_counter", 96'(pixel_counter), 96'(64));
      cyc1();
      chk("stream_ready_after_16", 96'(pkt_ready), 96'(0));
      chk("stream_accepts", 96'(n_acc), 96'(16));
      for (int k = 0; k < TOTAL; k++) begin
         kb = 8'(k);
         chk("stream_addr", 96'(w_addr[k]), 96'(k));
         chk("stream_red", 96'(w_red[k]), 96'({4{kb}}));
         chk("stream_green", 96'(w_grn[k]), 96'({4{kb}}));
         chk("stream_blue", 96'(w_blu[k]), 96'({4{kb}}));
         if (k > 0) chk("stream_spacing", 96'(w_cyc[k] - w_cyc[k-1]), 96'(1));
      end
      pkt_valid = 1'b0; img_ctrl_start = 1'b0;
      cyc1();

      // Unpacking of a single packet.
      clear_logs();
      img_ctrl_start = 1'b1;
      cyc1();
      pkt_valid = 1'b1; pkt_data = 96'h0A0B0C_1A1B1C_2A2B2C_3A3B3C;
      cyc1();
      pkt_valid = 1'b0;
      repeat (3) cyc1();
      chk("unpack_writes", 96'(w_addr.size()), 96'(1));
      chk("unpack_addr", 96'(w_addr[0]), 96'(0));
      chk("unpack_red", 96'(w_red[0]), 96'(32'h0A1A2A3A));
      chk("unpack_green", 96'(w_grn[0]), 96'(32'h0B1B2B3B));
      chk("unpack_blue", 96'(w_blu[0]), 96'(32'h0C1C2C3C));
      chk("unpack_latency", 96'(w_cyc[0] - a_cyc[0]), 96'(1));
      activate_burst = 1'b0; img_ctrl_start = 1'b0;
      cyc1();
      activate_burst = 1'b1;

      // Backpressure: write path stalled, FIFO fills, then drains in order.
      clear_logs();
      img_ctrl_start = 1'b1;
      cyc1();
      force dut.wr_en_gate = 1'b0;
      stall = 1'b1;
      for (int k = 0; k < 8; k++) begin
         pkt_valid = (n_acc < 5); pkt_data = mk(n_acc);
         cyc1();
      end
      chk("bp_accepts_full", 96'(n_acc), 96'(4));
      chk("bp_ready_full", 96'(pkt_ready), 96'(0));
      chk("bp_no_writes", 96'(w_addr.size()), 96'(0));
      release dut.wr_en_gate;
      stall = 1'b0;
      for (int k = 0; k < 20 && w_addr.size() < 5; k++) begin
         pkt_valid = (n_acc < 5); pkt_data = mk(n_acc);
         cyc1();
      end
      pkt_valid = 1'b0;
      chk("bp_writes", 96'(w_addr.size()), 96'(5));
      for (int k = 0; k < 5; k++) begin
         kb = 8'(k);
         chk("bp_order_addr", 96'(w_addr[k]), 96'(k));
         chk("bp_order_red", 96'(w_red[k]), 96'({4{kb}}));
      end
      chk("bp_late_accept", 96'(a_cyc[4]), 96'(w_cyc[0] + 1));
      activate_burst = 1'b0; img_ctrl_start = 1'b0;
      cyc1();
      activate_burst = 1'b1;

      // Abort after 7 writes, then restart from address 0.
      clear_logs();
      img_ctrl_start = 1'b1;
      run_until_writes(7, 60, 1'b0, "abort_pre");
      activate_burst = 1'b0; pkt_valid = 1'b0;
      cyc1();
      chk("abort_writes", 96'(w_addr.size()), 96'(7));
      chk("abort_pixel_counter", 96'(pixel_counter), 96'(0));
      chk("abort_frame_active", 96'(rx_frame_active), 96'(0));
      chk("abort_img_complete", 96'(img_complete), 96'(0));
      clear_logs();
      activate_burst = 1'b1;
      run_until_writes(3, 30, 1'b0, "restart");
      chk("restart_addr0", 96'(w_addr[0]), 96'(0));
      chk("restart_addr2", 96'(w_addr[2]), 96'(2));
      chk("restart_pixel_counter", 96'(pixel_counter), 96'(12));

      // Reset mid-frame.
      run_until_writes(5, 30, 1'b0, "reset_pre");
      rst_n = 1'b0; img_ctrl_start = 1'b0;
      #1;
      chk("rst_mid_pixel_counter", 96'(pixel_counter), 96'(0));
      chk("rst_mid_ready", 96'(pkt_ready), 96'(0));
      chk("rst_mid_write_en", 96'(red_write_en), 96'(0));
      chk("rst_mid_frame_active", 96'(rx_frame_active), 96'(0));
      chk("rst_mid_img_complete", 96'(img_complete), 96'(0));
      repeat (2) cyc1();
      rst_n = 1'b1;
      clear_logs();
      pkt_valid = 1'b1;
      repeat (5) cyc1();
      pkt_valid = 1'b0;
      chk("rst_after_accepts", 96'(n_acc), 96'(0));
      chk("rst_after_writes", 96'(w_addr.size()), 96'(0));

      // Randomized full frames with random valid gaps and data.
      for (int f = 0; f < 3; f++) begin
         img_ctrl_start = 1'b0; pkt_valid = 1'b0;
         cyc1();
         clear_logs();
         img_ctrl_start = 1'b1;
         run_until_writes(TOTAL, 400, 1'b1, "rand_frame");
         chk("rand_img_complete", 96'(img_complete), 96'(1));
         chk("rand_accepts", 96'(n_acc), 96'(16));
      end

      // Randomized abort point.
      img_ctrl_start = 1'b0; pkt_valid = 1'b0;
      cyc1();
      clear_logs();
      img_ctrl_start = 1'b1;
      run_until_writes($urandom_range(2, 14), 200, 1'b1, "rand_abort");
      activate_burst = 1'b0; pkt_valid = 1'b0;
      cyc1();
      chk("rand_abort_pixel_counter", 96'(pixel_counter), 96'(0));
      img_ctrl_start = 1'b0;
      repeat (2) cyc1();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
